// File: rtl/demux_wide_narrow.sv
// Wide-to-narrow demultiplexer: slices each W_IN word into N = W_IN/W_OUT
// output symbols, with a one-word pending buffer so a new word can be taken
// while the current one is still being emitted.
module demux_wide_narrow #(
    parameter int unsigned         W_IN      = 32,
    parameter int unsigned         W_OUT     = 8,
    parameter int unsigned         MSB_FIRST = 1,
    parameter logic [W_OUT-1:0]    IDLE_SYM  = W_OUT'(8'hBC)
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [W_IN-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W_OUT-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned N     = W_IN / W_OUT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Reject widths that do not split into at least two whole slices.
    if ((W_IN % W_OUT) != 0 || N < 2) begin : g_bad_cfg
        $error("demux_wide_narrow: W_IN must be a multiple of W_OUT with N >= 2");
    end

    logic [W_IN-1:0]  cur_q, cur_d;
    logic [W_IN-1:0]  nxt_q, nxt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             nxt_full_q, nxt_full_d;

    logic             accept;
    logic             xfer;
    logic             at_last;
    logic             refill;
    logic [W_OUT-1:0] slice;

    assign in_ready = !nxt_full_q;
    assign accept   = in_valid & in_ready;
    assign xfer     = busy_q & out_ready;
    assign at_last  = (idx_q == LAST_IDX);

    // Select slice idx of the current word in the configured order.
    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                if (MSB_FIRST != 0) slice = cur_q[W_IN-1-i*W_OUT -: W_OUT];
                else                slice = cur_q[i*W_OUT +: W_OUT];
            end
        end
    end

    // Output drive: idle symbol whenever nothing is being sliced.
    always_comb begin
        out_valid = busy_q;
        out_last  = busy_q & at_last;
        out_data  = busy_q ? slice : IDLE_SYM;
    end

    // Next-state: load/advance cur, park an early word in nxt.
    always_comb begin
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        nxt_full_d = nxt_full_q;
        refill     = 1'b0;

        if (!busy_q) begin
            if (accept) begin
                cur_d  = in_data;
                idx_d  = '0;
                busy_d = 1'b1;
                refill = 1'b1;
            end
        end else if (xfer) begin
            if (!at_last) begin
                idx_d = idx_q + IDX_W'(1);
            end else if (nxt_full_q) begin
                cur_d      = nxt_q;
                idx_d      = '0;
                nxt_full_d = 1'b0;
                refill     = 1'b1;
            end else if (accept) begin
                // Bypass: the new word goes straight into cur, no bubble.
                cur_d  = in_data;
                idx_d  = '0;
                refill = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end

        // nxt is only written when empty, since accept implies !nxt_full.
        if (busy_q && accept && !refill) begin
            nxt_d      = in_data;
            nxt_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cur_q      <= '0;
            nxt_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            nxt_full_q <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            nxt_full_q <= nxt_full_d;
        end
    end

endmodule

// File: tb/tb_demux_wide_narrow.sv
// Bench for demux_wide_narrow: three instances (MSB-first 32/8, LSB-first 32/8,
// MSB-first 64/16) share one stimulus stream; each is tracked by a queue of
// expected output slices.
module tb_demux_wide_narrow;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv;
    logic        ordy;
    logic [63:0] din;

    logic        rdy_m, vld_m, last_m;
    logic [7:0]  dat_m;
    logic        rdy_l, vld_l, last_l;
    logic [7:0]  dat_l;
    logic        rdy_w, vld_w, last_w;
    logic [15:0] dat_w;

    demux_wide_narrow #(.W_IN(32), .W_OUT(8), .MSB_FIRST(1), .IDLE_SYM(8'hBC)) dut_m (
        .clk_4f(clk), .reset(rst), .in_data(din[31:0]), .in_valid(iv), .in_ready(rdy_m),
        .out_data(dat_m), .out_valid(vld_m), .out_ready(ordy), .out_last(last_m)
    );

    demux_wide_narrow #(.W_IN(32), .W_OUT(8), .MSB_FIRST(0), .IDLE_SYM(8'hBC)) dut_l (
        .clk_4f(clk), .reset(rst), .in_data(din[31:0]), .in_valid(iv), .in_ready(rdy_l),
        .out_data(dat_l), .out_valid(vld_l), .out_ready(ordy), .out_last(last_l)
    );

    demux_wide_narrow #(.W_IN(64), .W_OUT(16), .MSB_FIRST(1), .IDLE_SYM(16'hBCBC)) dut_w (
        .clk_4f(clk), .reset(rst), .in_data(din), .in_valid(iv), .in_ready(rdy_w),
        .out_data(dat_w), .out_valid(vld_w), .out_ready(ordy), .out_last(last_w)
    );

    int checks = 0;
    int failures = 0;

    // Expected slices still to be emitted, oldest first.
    logic [15:0] q_m[$];
    logic [15:0] q_l[$];
    logic [15:0] q_w[$];

    // Logs of transferred slices for directed sequence checks.
    logic [31:0] log_m;
    logic [31:0] log_l;
    logic [63:0] log_w;
    logic [3:0]  lastlog_m;
    int          xfer_cnt;
    int          last_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // A word occupies N=4 queue entries; the block holds at most two words.
    task automatic chk_dut(input string t, input int sz, input logic [15:0] exp_dat,
                           input logic o_rdy, input logic o_vld, input logic [15:0] o_dat,
                           input logic o_last);
        chk({t, ".in_ready"},  64'(o_rdy),  64'(((sz + 3) / 4) < 2));
        chk({t, ".out_valid"}, 64'(o_vld),  64'(sz > 0));
        chk({t, ".out_data"},  64'(o_dat),  64'(exp_dat));
        chk({t, ".out_last"},  64'(o_last), 64'((sz % 4) == 1));
    endtask

    task automatic push_word(input logic [63:0] w);
        logic [31:0] n;
        n = w[31:0];
        for (int k = 0; k < 4; k++) begin
            q_m.push_back(16'((n >> (8 * (3 - k))) & 32'hFF));
            q_l.push_back(16'((n >> (8 * k)) & 32'hFF));
            q_w.push_back(16'((w >> (16 * (3 - k))) & 64'hFFFF));
        end
    endtask

    // Check outputs at the falling edge, then advance the model by one clock.
    task automatic cycle();
        int          sz;
        logic        acc;
        logic        xf;
        sz  = q_m.size();
        chk_dut("msb",  sz, (sz > 0) ? q_m[0] : 16'h00BC, rdy_m, vld_m, {8'h00, dat_m}, last_m);
        chk_dut("lsb",  q_l.size(), (q_l.size() > 0) ? q_l[0] : 16'h00BC, rdy_l, vld_l,
                {8'h00, dat_l}, last_l);
        chk_dut("wide", q_w.size(), (q_w.size() > 0) ? q_w[0] : 16'hBCBC, rdy_w, vld_w,
                dat_w, last_w);
        acc = iv && (((sz + 3) / 4) < 2);
        xf  = (sz > 0) && ordy;
        if (!rst && vld_m && ordy) begin
            log_m     = {log_m[23:0], dat_m};
            log_l     = {log_l[23:0], dat_l};
            log_w     = {log_w[47:0], dat_w};
            lastlog_m = {lastlog_m[2:0], last_m};
            xfer_cnt++;
            if (last_m) last_cnt++;
        end
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            q_l.delete();
            q_w.delete();
        end else begin
            if (xf) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                void'(q_w.pop_front());
            end
            if (acc) push_word(din);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        log_m = '0; log_l = '0; log_w = '0; lastlog_m = '0; xfer_cnt = 0; last_cnt = 0;
    endtask

    logic [31:0] words[4];
    bit          done;

    initial begin
        words = '{32'hAABBAACC, 32'hBBAABBEE, 32'hCCAACCDD, 32'hAADDEEDD};
        clear_logs();
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; din = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Reset state, with in_valid asserted to show it is ignored.
        iv = 1'b1; din = 64'h1111_2222_3333_4444;
        cycle();
        rst = 1'b0; iv = 1'b0;
        cycle();

        // MSB/LSB single word.
        clear_logs();
        iv = 1'b1; din = 64'h0000_0000_AABB_AACC;
        cycle();
        iv = 1'b0;
        repeat (6) cycle();
        chk("single.msb_order", 64'(log_m), 64'h0000_0000_AABB_AACC);
        chk("single.lsb_order", 64'(log_l), 64'h0000_0000_CCAA_BBAA);
        chk("single.last_pos",  64'(lastlog_m), 64'h1);
        chk("single.idle_data", 64'(dat_m), 64'hBC);

        // Streaming: one word every 4 cycles.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; din = {32'h0, words[i]};
            cycle();
            iv = 1'b0;
            repeat (3) cycle();
        end
        repeat (4) cycle();
        chk("stream.xfers", 64'(xfer_cnt), 64'd16);
        chk("stream.lasts", 64'(last_cnt), 64'd4);

        // Backpressure.
        iv = 1'b1; din = 64'hAABBAACC; ordy = 1'b1;
        cycle();
        iv = 1'b0;
        cycle();
        ordy = 1'b0; iv = 1'b1; din = 64'hBBAABBEE;
        chk("bp.held_first", 64'(dat_m), 64'hBB);
        cycle();
        din = 64'hCCAACCDD;
        chk("bp.full_ready", 64'(rdy_m), 64'h0);
        cycle();
        cycle();
        chk("bp.held_last", 64'(dat_m), 64'hBB);
        ordy = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            done = rdy_m;
            cycle();
        end
        chk("bp.third_accepted", 64'(done), 64'h1);
        iv = 1'b0;
        repeat (12) cycle();

        // Reset mid-word, after the second slice.
        iv = 1'b1; din = 64'hAABBAACC;
        cycle();
        iv = 1'b0;
        cycle();
        cycle();
        rst = 1'b1; iv = 1'b1; din = 64'h5566_7788_99AA_BBCC;
        cycle();
        rst = 1'b0; iv = 1'b0;
        chk("rst_mid.valid", 64'(vld_m), 64'h0);
        chk("rst_mid.data",  64'(dat_m), 64'hBC);
        chk("rst_mid.ready", 64'(rdy_m), 64'h1);
        repeat (5) cycle();

        // Wide configuration.
        clear_logs();
        iv = 1'b1; din = 64'h0123_4567_89AB_CDEF;
        cycle();
        iv = 1'b0;
        repeat (6) cycle();
        chk("wide.order", log_w, 64'h0123_4567_89AB_CDEF);
        chk("wide.idle",  64'(dat_w), 64'hBCBC);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 800; n++) begin
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            din  = {$urandom, $urandom};
            rst  = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0; iv = 1'b0; ordy = 1'b1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
